// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,dvd} left, trial-subtract divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] dvd_n,
    output logic             qbit
);

    logic [WIDTH:0] rem_s;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_s = {rem, dvd[WIDTH-1]};
        diff  = rem_s - {1'b0, divisor};
        // No borrow out of the extra bit means rem_s >= divisor
        qbit  = ~diff[WIDTH];
        rem_n = qbit ? diff[WIDTH-1:0] : rem_s[WIDTH-1:0];
        dvd_n = {dvd[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/divider_iterative.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned per op.
module divider_iterative
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] dvd_n;
    logic             qbit;
    logic             sign_q;
    logic             sign_r;
    logic             dz_r;
    logic             accept;
    logic             last_step;
    logic             b_zero;
    logic             neg_a;
    logic             neg_b;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem    (rem_r),
        .dvd    (dvd_r),
        .divisor(dsr_r),
        .rem_n  (rem_n),
        .dvd_n  (dvd_n),
        .qbit   (qbit)
    );

    always_comb begin
        state_n   = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_valid && (state == IDLE);
        last_step = (state == BUSY) && (cnt == LAST);
        case (state)
            IDLE:    if (accept) state_n = BUSY;
            BUSY:    if (last_step) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Divide-by-zero runs as unsigned on the raw dividend, so the plain
    // restoring recurrence yields q=all ones and r=a with no sign fix.
    always_comb begin
        b_zero = (b == '0);
        neg_a  = is_signed && a[WIDTH-1] && !b_zero;
        neg_b  = is_signed && b[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem_r    <= '0;
            dvd_r    <= '0;
            dsr_r    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_r     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            rem_r  <= '0;
            dvd_r  <= neg_a ? -a : a;
            dsr_r  <= neg_b ? -b : b;
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            dz_r   <= b_zero;
        end else if (state == BUSY) begin
            rem_r <= rem_n;
            dvd_r <= dvd_n;
            if (last_step) begin
                // Final step result goes straight to the outputs so out_valid
                // rises on the same edge as the last quotient bit.
                q        <= sign_q ? -dvd_n : dvd_n;
                r        <= sign_r ? -rem_n : rem_n;
                div_zero <= dz_r;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: directed vectors, latency, backpressure, abort.
module tb_divider_iterative;
    import div_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    logic        prev_ov = 1'b0;

    divider_iterative #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compares held outputs to the scoreboard head every cycle and pops on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov)
                check("latency", W'(cyc - acc_cyc), W);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got out_valid q=%h r=%h want no result", q, r);
                end else begin
                    check("q", q, sb[0].q);
                    check("r", r, sb[0].r);
                    check("div_zero", W'(div_zero), W'(sb[0].dz));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
        prev_ov <= out_valid;
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        @(posedge clk); #1;
        check("in_ready_idle", W'(in_ready), W'(1));
        a = av;
        b = bv;
        is_signed = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < int'(W) + 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = edz;
        sb.push_back(e);
        issue(av, bv, s);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        exp_t e;

        #23;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_q", q, '0);
        check("rst_r", r, '0);
        check("rst_div_zero", W'(div_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd100,      32'd7,      1'b0, 32'd14,       32'd2,        1'b0);
        run_op(32'hFFFFFF9C, 32'd7,      1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        run_op(32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,      1'b0);
        run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,     32'hFFFFFFFE, 1'b0);
        run_op(32'h00001234, 32'd0,      1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1);
        run_op(32'hFFFFFF9C, 32'd0,      1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1);
        run_op(32'hFFFFFFFF, 32'd1,      1'b0, 32'hFFFFFFFF, 32'd0,        1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,      1'b0);
        run_op(32'hFFFFFFF9, 32'd2,      1'b0, 32'h7FFFFFFC, 32'd1,        1'b0);
        run_op(32'd7,        32'd100,    1'b0, 32'd0,        32'd7,        1'b0);

        // Backpressure: result held for 10 cycles while new requests are ignored
        out_ready = 1'b0;
        e.q  = 32'd100;
        e.r  = 32'd0;
        e.dz = 1'b0;
        sb.push_back(e);
        issue(32'd1000, 32'd10, 1'b0);
        n = 0;
        while (!out_valid && n < int'(W) + 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid", W'(out_valid), W'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a = 32'd7;
            b = 32'd1;
            is_signed = 1'b0;
            in_valid = 1'b1;
            check("bp_in_ready", W'(in_ready), W'(0));
            check("bp_valid_held", W'(out_valid), W'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", W'(in_ready), W'(1));
        check("bp_out_valid_after", W'(out_valid), W'(0));
        check("bp_sb_empty", W'(sb.size()), W'(0));

        // Abort mid-BUSY via reset; no result may appear for this op
        issue(32'h55, 32'd3, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_q", q, '0);
        check("abort_r", r, '0);
        check("abort_div_zero", W'(div_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(W) + 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", W'(seen), W'(0));

        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
